// File: rtl/fc_argmax.sv
// fc_argmax: sequential fully-connected layer (N_IN -> N_OUT) with
// saturated 16-bit class scores and a sequential argmax over them.
module fc_argmax #(
    parameter int N_IN  = 64,
    parameter int N_OUT = 10,
    parameter int DW    = 16,
    parameter int WW    = 8,
    parameter int WFRAC = 7,
    parameter int WA_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [5:0]           feat_idx,
    input  logic signed [DW-1:0] feat_in,
    output logic [WA_W-1:0]      w_addr,
    input  logic signed [WW-1:0] w_data,
    input  logic [3:0]           sel,
    output logic signed [DW-1:0] score_o,
    output logic [3:0]           class_o,
    output logic                 busy,
    output logic                 done
);

    localparam int KW = $clog2(N_IN + 2);
    localparam int AW = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_STORE,
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [KW-1:0]        k_q;
    logic [3:0]           o_q;
    logic [3:0]           a_q;
    logic [WA_W-1:0]      base_q;
    logic                 vld_q;
    logic                 bias_q;
    logic signed [AW-1:0] acc_q;
    logic signed [DW-1:0] score_q [N_OUT];
    logic signed [DW-1:0] best_q;
    logic [3:0]           bidx_q;
    logic [3:0]           class_q;

    logic                    issue;
    logic signed [DW+WW-1:0] prod;
    logic signed [AW-1:0]    bias_ext;
    logic signed [AW-1:0]    acc_add;
    logic signed [AW-1:0]    shifted;
    logic signed [DW-1:0]    sat;
    logic signed [DW-1:0]    cur;
    logic                    take;

    // Next-state logic of the sequencing FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_MAC;
            S_MAC:    if (k_q == KW'(N_IN + 1)) state_d = S_STORE;
            S_STORE:  state_d = (o_q == 4'(N_OUT - 1)) ? S_ARGMAX : S_MAC;
            S_ARGMAX: if (a_q == 4'(N_OUT - 1)) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Address issue, MAC operand shaping, saturation and argmax compare
    always_comb begin
        issue    = (state_q == S_MAC) && (k_q <= KW'(N_IN));
        feat_idx = '0;
        w_addr   = '0;
        if (issue) begin
            feat_idx = (k_q >= KW'(N_IN)) ? 6'(N_IN - 1) : 6'(k_q);
            w_addr   = base_q + WA_W'(k_q);
        end
        prod     = feat_in * w_data;
        bias_ext = {{(AW - WW){w_data[WW-1]}}, w_data} <<< WFRAC;
        acc_add  = bias_q ? bias_ext
                          : {{(AW - DW - WW){prod[DW+WW-1]}}, prod};
        shifted  = acc_q >>> WFRAC;
        if (shifted > 32'sd32767)       sat = 16'sh7fff;
        else if (shifted < -32'sd32768) sat = 16'sh8000;
        else                            sat = shifted[DW-1:0];
        cur  = score_q[a_q];
        take = (a_q == 4'd0) || (cur > best_q);
    end

    // Datapath registers: counters, accumulator, scores, argmax
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q     <= '0;
            o_q     <= '0;
            a_q     <= '0;
            base_q  <= '0;
            vld_q   <= 1'b0;
            bias_q  <= 1'b0;
            acc_q   <= '0;
            best_q  <= '0;
            bidx_q  <= '0;
            class_q <= '0;
            for (int i = 0; i < N_OUT; i++) score_q[i] <= '0;
        end else begin
            vld_q  <= issue;
            bias_q <= issue && (k_q == KW'(N_IN));
            if (vld_q) acc_q <= acc_q + acc_add;
            unique case (state_q)
                S_IDLE: begin
                    k_q    <= '0;
                    o_q    <= '0;
                    a_q    <= '0;
                    base_q <= '0;
                end
                S_MAC: k_q <= k_q + KW'(1);
                S_STORE: begin
                    score_q[o_q] <= sat;
                    acc_q        <= '0;
                    k_q          <= '0;
                    o_q          <= o_q + 4'd1;
                    base_q       <= base_q + WA_W'(N_IN + 1);
                end
                S_ARGMAX: begin
                    a_q <= a_q + 4'd1;
                    if (take) begin
                        best_q <= cur;
                        bidx_q <= a_q;
                    end
                    if (a_q == 4'(N_OUT - 1))
                        class_q <= take ? a_q : bidx_q;
                end
                default: ;
            endcase
        end
    end

    // Score readback mux and status outputs
    always_comb begin
        score_o = '0;
        for (int i = 0; i < N_OUT; i++)
            if (sel == 4'(i)) score_o = score_q[i];
        class_o = class_q;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
    end

endmodule

// File: doc/fc_argmax.md
# fc_argmax

Sequential fully-connected classifier stage that sits directly downstream of the 64 conv/pool units. On a start pulse it walks the 64 pooled feature values through a single signed multiply-accumulate for each of 10 output neurons, adds a per-neuron bias, and saturates each result to a 16-bit class score. It then runs a sequential argmax over the 10 scores and reports the predicted class with a one-cycle done pulse. Weights and features come from external synchronous-read sources (1-cycle latency).

## Interface
Parameters:
- N_IN, 64, number of input features per neuron
- N_OUT, 10, number of output neurons / classes
- DW, 16, signed feature and score width
- WW, 8, signed weight/bias word width
- WFRAC, 7, weight fractional bits (result shift)
- WA_W, 10, weight address width (≥ clog2(N_OUT*(N_IN+1)))

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin classification; sampled only in IDLE
- feat_idx  out  6  feature select to the unit result mux
- feat_in  in  DW  signed feature; valid the cycle after feat_idx is driven
- w_addr  out  WA_W  weight ROM address
- w_data  in  WW  signed weight/bias; valid the cycle after w_addr is driven
- sel  in  4  score readback select (combinational mux)
- score_o  out  DW  stored score[sel]; 0 if sel ≥ N_OUT
- class_o  out  4  predicted class index
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when class_o is valid

## Operation
- FSM: IDLE → MAC → STORE → (MAC for the next neuron | ARGMAX) → DONE → IDLE.
- Weight layout: w_addr = o*(N_IN+1)+k. For k < N_IN the word is a weight. k = N_IN is the neuron's bias.
- MAC, neuron o, issue cycles k = 0..N_IN:
  - Drive feat_idx = k (held at N_IN-1 when k = N_IN) and the matching w_addr.
  - In the following cycle, accumulate into a signed 32-bit acc:
    - k < N_IN: acc += feat_in*w_data
    - k = N_IN: acc += sign-extended w_data <<< WFRAC
- STORE:
  - score[o] = saturate(acc >>> WFRAC) to [-32768, 32767] (arithmetic shift).
  - Clear acc, then o++.
- ARGMAX:
  - Scan o = 0..N_OUT-1, one score per cycle.
  - Replace the running best only on strictly greater, so ties resolve to the lowest index.
  - Best is initialised from score[0].
- DONE: class_o updated, done = 1 for one cycle, busy drops, return to IDLE.
- class_o and the score registers hold their values until the next completed run or reset.
- start while busy is ignored. start held high in IDLE restarts immediately after DONE.
- rst at any point:
  - FSM → IDLE, acc and all scores → 0, class_o → 0, busy/done → 0.
  - feat_idx and w_addr → 0.
  - No done pulse is generated for an aborted run.

## Timing
- Reset values: busy 0, done 0, class_o 0, score_o 0, feat_idx 0, w_addr 0.
- Start accepted on edge E0; busy is high from the cycle after E0.
- Per neuron: N_IN+1 issue cycles, 1 drain cycle, 1 STORE cycle, for N_IN+3 = 67 cycles.
- Argmax takes N_OUT = 10 cycles; DONE takes 1 cycle.
- done is high exactly N_OUT*(N_IN+3)+N_OUT+1 = 681 cycles after E0. busy is low in the cycle after done.
- Memory contract: feat_in and w_data are sampled one cycle after their address, with no stall path.
- The product is a full 24-bit signed value. 64 terms cannot overflow the 32-bit acc, so saturation applies only at STORE.

## Test plan
- Reset: assert rst for 3 cycles. Expect all outputs 0, busy 0, and no done for 1000 idle cycles.
- Ramp weights: all features 256 (1.0), every weight of neuron o = o, biases 0, pulse start. Expect score[o] = 128*o (score[9] = 1152), class_o = 9, and done exactly 681 cycles after E0.
- Saturation: features 32767 with weights 127 give all scores 32767. Weights -128 give all scores -32768. class_o = 0 in both cases (tie).
- Bias and tie: all weights 0, bias words of neurons 3 and 7 = 5, all others -1. Expect score[3] = score[7] = 5, others -1, class_o = 3.
- Busy protection: a second start pulse at cycle 100 of a run is ignored, giving a single done at 681. Start held high continuously gives back-to-back runs with done every 682 cycles.
- Reset mid-run: rst at cycle 300. Expect busy 0 and class_o 0 the next cycle and no done. A fresh start then completes with the correct result at +681.
